// File: rtl/pr3_frame_tx.sv
// PR3 frame transmitter: buffers the 32-bit word stream and serialises whole frames as sync/payload/checksum bytes.
// Defining PR3_FRAME_STATUS_EN adds a status byte (drop count) ahead of the checksum.
module pr3_frame_tx #(
   parameter int unsigned WPF   = 18,
   parameter int unsigned DEPTH = 64,
   parameter logic [15:0] SYNC  = 16'hA55A
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        sink_valid,
   input  logic [31:0] sink_data,
   input  logic        source_ready,
   output logic        source_valid,
   output logic        source_sop,
   output logic        source_eop,
   output logic [7:0]  source_data,
   output logic        overflow,
   output logic [7:0]  drop_count
);
   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned FW = AW + 1;
   localparam int unsigned IW = (WPF > 1) ? $clog2(WPF) : 1;

`ifdef PR3_FRAME_STATUS_EN
   typedef enum logic [2:0] {IDLE, SYNC_H, SYNC_L, PAYLOAD, STATUS, CHECK} state_t;
   logic [7:0] status, status_nxt;
`else
   typedef enum logic [2:0] {IDLE, SYNC_H, SYNC_L, PAYLOAD, CHECK} state_t;
`endif

   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr, wr_inc_c, rd_inc_c;
   logic [FW-1:0] fill, frame_cnt;
   logic [IW-1:0] wi, wc, wc_nxt;
   logic [1:0]    bi, bi_nxt;
   logic [7:0]    chk, chk_nxt, data_nxt;
   logic          in_admit, valid_nxt, sop_nxt, eop_nxt;
   logic          accept_c, pop_c, admit_c, push_c, frame_in_c, frame_out_c, start_c;
   logic [31:0]   free_c;
   state_t        state, state_nxt;

   function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] i);
      case (i)
         2'd0:    byte_sel = w[31:24];
         2'd1:    byte_sel = w[23:16];
         2'd2:    byte_sel = w[15:8];
         default: byte_sel = w[7:0];
      endcase
   endfunction

   // Admission: a frame is taken only if all its words are guaranteed to fit.
   always_comb begin
      accept_c   = source_valid && source_ready;
      pop_c      = accept_c && (state == PAYLOAD) && (bi == 2'd3);
      free_c     = DEPTH - 32'(fill) + 32'(pop_c);
      admit_c    = (wi == '0) ? (free_c >= WPF) : in_admit;
      push_c     = sink_valid && admit_c;
      frame_in_c = push_c && (wi == IW'(WPF - 1));
      wr_inc_c   = (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
      rd_inc_c   = (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
   end

   always_ff @(posedge clk) begin
      if (push_c) mem[wr_ptr] <= sink_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wi         <= '0;
         in_admit   <= 1'b0;
         overflow   <= 1'b0;
         drop_count <= 8'd0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fill       <= '0;
         frame_cnt  <= '0;
      end else begin
         if (sink_valid) begin
            wi <= (wi == IW'(WPF - 1)) ? '0 : wi + IW'(1);
            if (wi == '0) begin
               in_admit <= admit_c;
               if (!admit_c) begin
                  overflow <= 1'b1;
                  if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
               end
            end
         end
         if (push_c) wr_ptr <= wr_inc_c;
         if (pop_c)  rd_ptr <= rd_inc_c;
         fill      <= fill + FW'(push_c) - FW'(pop_c);
         frame_cnt <= frame_cnt + FW'(frame_in_c) - FW'(frame_out_c);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         source_valid <= 1'b0;
         source_sop   <= 1'b0;
         source_eop   <= 1'b0;
         source_data  <= 8'd0;
         chk          <= 8'd0;
         bi           <= 2'd0;
         wc           <= '0;
`ifdef PR3_FRAME_STATUS_EN
         status       <= 8'd0;
`endif
      end else begin
         state        <= state_nxt;
         source_valid <= valid_nxt;
         source_sop   <= sop_nxt;
         source_eop   <= eop_nxt;
         source_data  <= data_nxt;
         chk          <= chk_nxt;
         bi           <= bi_nxt;
         wc           <= wc_nxt;
`ifdef PR3_FRAME_STATUS_EN
         status       <= status_nxt;
`endif
      end
   end

   // Next-state logic computes the byte to present next; everything holds while stalled.
   always_comb begin
      state_nxt   = state;
      valid_nxt   = source_valid;
      sop_nxt     = source_sop;
      eop_nxt     = source_eop;
      data_nxt    = source_data;
      chk_nxt     = chk;
      bi_nxt      = bi;
      wc_nxt      = wc;
      frame_out_c = 1'b0;
      start_c     = 1'b0;
`ifdef PR3_FRAME_STATUS_EN
      status_nxt  = status;
`endif
      case (state)
         IDLE: start_c = (frame_cnt != '0);
         SYNC_H: if (accept_c) begin
            state_nxt = SYNC_L;
            sop_nxt   = 1'b0;
            data_nxt  = SYNC[7:0];
         end
         SYNC_L: if (accept_c) begin
            state_nxt = PAYLOAD;
            bi_nxt    = 2'd0;
            wc_nxt    = '0;
            data_nxt  = byte_sel(mem[rd_ptr], 2'd0);
         end
         PAYLOAD: if (accept_c) begin
            chk_nxt = chk ^ source_data;
            if (bi != 2'd3) begin
               bi_nxt   = bi + 2'd1;
               data_nxt = byte_sel(mem[rd_ptr], bi + 2'd1);
            end else if (wc == IW'(WPF - 1)) begin
`ifdef PR3_FRAME_STATUS_EN
               state_nxt = STATUS;
               data_nxt  = status;
`else
               state_nxt = CHECK;
               data_nxt  = chk ^ source_data;
               eop_nxt   = 1'b1;
`endif
            end else begin
               wc_nxt   = wc + IW'(1);
               bi_nxt   = 2'd0;
               data_nxt = byte_sel(mem[rd_inc_c], 2'd0);
            end
         end
`ifdef PR3_FRAME_STATUS_EN
         STATUS: if (accept_c) begin
            state_nxt = CHECK;
            chk_nxt   = chk ^ source_data;
            data_nxt  = chk ^ source_data;
            eop_nxt   = 1'b1;
         end
`endif
         CHECK: if (accept_c) begin
            frame_out_c = 1'b1;
            eop_nxt     = 1'b0;
            state_nxt   = IDLE;
            valid_nxt   = 1'b0;
            start_c     = (frame_cnt > FW'(1));
         end
         default: state_nxt = IDLE;
      endcase
      if (start_c) begin
         state_nxt = SYNC_H;
         valid_nxt = 1'b1;
         sop_nxt   = 1'b1;
         eop_nxt   = 1'b0;
         data_nxt  = SYNC[15:8];
         chk_nxt   = 8'd0;
`ifdef PR3_FRAME_STATUS_EN
         status_nxt = drop_count;
`endif
      end
   end
endmodule

// File: doc/pr3_frame_tx.md
Name: pr3_frame_tx

Overview:
- Downstream stage of the PR3 phase-extraction top level.
- Consumes the 32-bit word stream (source_valid/source_data: block header word followed by peak data words) and buffers it in a word FIFO.
- Serialises whole frames as a byte stream with a ready/valid handshake: sync bytes, big-endian payload, XOR checksum.
- The PR3 stream has no backpressure, so this block drops whole frames on overflow to keep frame alignment.

Parameters:
- WPF, 18, words per frame (header plus data words, all antenna blocks of one run); ≥1.
- DEPTH, 64, FIFO depth in 32-bit words; power of two; DEPTH ≥ WPF.
- SYNC, 16'hA55A, two sync bytes; high byte is sent first.

Ports:
- clk  in  1  main clock
- reset  in  1  synchronous reset, active-high
- sink_valid  in  1  input word valid; no backpressure
- sink_data  in  32  input word
- source_ready  in  1  downstream accepts byte
- source_valid  out  1  output byte valid
- source_sop  out  1  first byte of frame (SYNC high byte)
- source_eop  out  1  last byte of frame (checksum)
- source_data  out  8  output byte
- overflow  out  1  sticky: set when any frame has been dropped
- drop_count  out  8  dropped-frame count, saturates at 255

Behaviour:
- Reset, synchronous, active-high: source_valid/sop/eop=0, source_data=0, overflow=0, drop_count=0, FIFO emptied, input word index=0, FSM=IDLE, checksum=0.
- Reset mid-frame (input or output) abandons the frame immediately; no partial frame is emitted afterwards.
- Input side:
  - Word index wi counts 0..WPF-1 on each sink_valid and wraps to 0.
  - At wi==0 the block makes an admit decision: free space (DEPTH-fill, including a simultaneous read this cycle) ≥ WPF → admit; else drop.
  - A dropped frame discards all WPF words, sets overflow, increments drop_count (saturating).
  - Admitted words are written at one per cycle.
- Output FSM states: IDLE, SYNC_H, SYNC_L, PAYLOAD, [STATUS], CHECK.
  - IDLE→SYNC_H when number of complete admitted frames in FIFO ≥1. Tracked by a frame counter: +1 when the WPF-th admitted word is written, −1 when CHECK is accepted.
  - Latency: the frame counter becomes nonzero at cycle t; source_valid is asserted with SYNC[15:8] and source_sop=1 at t+1.
  - SYNC_H→SYNC_L→PAYLOAD, one state per accepted byte.
  - PAYLOAD sends each word MSB byte first (bits 31:24, 23:16, 15:8, 7:0). The FIFO word is popped when its byte 3 is accepted. After WPF words → CHECK (or STATUS when enabled).
  - CHECK: byte = XOR of all payload bytes (and status byte if present), source_eop=1. On accept → IDLE, or directly → SYNC_H when another frame is complete (back-to-back frames, no idle cycle).
- Handshake:
  - A byte transfers when source_valid && source_ready.
  - While source_valid && !source_ready, source_data/sop/eop are held stable.
  - source_valid is never deasserted before acceptance.
  - Outputs are registered; no combinational path from source_ready to source_valid.
- Checksum register clears at SYNC_H and accumulates each payload byte on acceptance.
- Input and output run concurrently. Simultaneous FIFO write and pop in the same cycle is legal and leaves fill unchanged.

Optional Feature:
- Macro PR3_FRAME_STATUS_EN.
- Defined: a STATUS state sits between PAYLOAD and CHECK. It emits one byte = drop_count sampled at the start of the frame (SYNC_H), and that byte is included in the checksum. Frame length = 2+4·WPF+2 bytes.
- Undefined: no STATUS state; frame length = 2+4·WPF+1 bytes.

Test Plan:
- WPF=2, ready=1, words 0x11223344, 0xAABBCCDD → bytes A5 5A 11 22 33 44 AA BB CC DD 44; sop on A5, eop on 44; A5 appears one cycle after the 2nd word is written.
- Same frame with source_ready toggling 1,0,0,1,… → identical byte sequence; data/sop/eop stable during every stall; no duplicated or lost bytes.
- WPF=2, DEPTH=4, ready=0, three frames in → frames 1–2 stored, frame 3 dropped, drop_count=1, overflow=1; then ready=1 → exactly two correct frames out, back-to-back, eop→next sop with no gap.
- Input frame arriving while the previous frame is being serialised → both frames out in order; fill never exceeds DEPTH.
- Reset asserted during PAYLOAD → next cycle source_valid=0, drop_count=0, overflow=0; a subsequent clean frame is output correctly.
- PR3_FRAME_STATUS_EN, one prior drop, WPF=2 frame as above → bytes A5 5A 11 22 33 44 AA BB CC DD 01 45.
